uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Frame-level command parser behind the UART receiver. Consumes the rx_done/rx_data byte stream,
//  hunts for a parametrised header and decodes an addressed, checksummed frame. Updates one of
//  NUM_CH independent {time_set, ctrl_set} register sets. Adds FSM framing, channel addressing,
//  checksum, inter-byte timeout and error reporting; a partial or bad frame never touches outputs.
// PARAMETERS
//  NUM_CH       4      number of command channels (1..256)
//  TIME_BYTES   4      time_set width in bytes per channel, big-endian on the wire (1..8)
//  HDR0         8'h55  first header byte
//  HDR1         8'hA5  second header byte
//  TAIL         8'hF0  frame tail byte
//  CHK_EN       1      1: a checksum byte precedes TAIL; 0: no checksum byte on the wire
//  TIMEOUT_CYC  50000  max clk cycles between bytes inside a frame; 0 disables the timeout
// PORTS
//  clk        in   1                    system clock
//  reset      in   1                    asynchronous, active-high reset
//  rx_done    in   1                    one-cycle strobe, rx_data valid
//  rx_data    in   8                    received byte
//  time_set   out  NUM_CH*TIME_BYTES*8  channel k occupies slice [k*TIME_BYTES*8 +: TIME_BYTES*8]
//  ctrl_set   out  NUM_CH*8             channel k occupies slice [k*8 +: 8]
//  cmd_valid  out  1                    one-cycle pulse: a channel was just updated
//  cmd_ch     out  8                    channel updated, valid while cmd_valid is high
//  frame_err  out  1                    one-cycle pulse: frame aborted
//  err_code   out  3                    1 bad addr, 2 checksum, 3 tail, 4 timeout; held until next err
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, shadow buffer and counters cleared. Reset mid-frame discards the frame.
//  Frame format: HDR0 HDR1 ADDR T[MSB..LSB](TIME_BYTES) CTRL [CHK] TAIL.
//   CHK is the XOR of ADDR through CTRL.
//  FSM: the state advances only on cycles where rx_done=1.
//   IDLE:  byte==HDR0 -> S_HDR1; any other byte -> stay in IDLE.
//   S_HDR1: byte==HDR1 -> S_ADDR; byte==HDR0 -> stay (resync); otherwise -> IDLE, no error.
//   S_ADDR: byte<NUM_CH -> latch ch, chk=byte, S_DATA; otherwise -> IDLE with err 1.
//   S_DATA: store into shadow[idx], chk^=byte, idx++.
//     After TIME_BYTES+1 bytes -> S_CHK when CHK_EN=1, else -> S_TAIL.
//   S_CHK:  byte==chk -> S_TAIL; otherwise -> IDLE with err 2.
//   S_TAIL: byte==TAIL -> commit, IDLE; otherwise -> IDLE with err 3 (this byte is not re-hunted as HDR0).
//  Commit: on the clk edge after the TAIL byte's rx_done cycle (1-cycle latency):
//   - the selected slices of time_set/ctrl_set take the shadow values;
//   - cmd_valid=1 and cmd_ch=ch in that same cycle;
//   - other channels are untouched.
//  Errors: frame_err pulses 1 cycle on the edge after the offending byte.
//   err_code updates with the pulse. Header mismatches are silent.
//  Timeout: the counter runs only outside IDLE and is cleared on every rx_done.
//   When it reaches TIMEOUT_CYC with no rx_done that cycle: -> IDLE with err 4.
//   If rx_done coincides with expiry, the byte is processed normally.
//  The next frame may start on the byte immediately after TAIL; the FSM is already in IDLE.
//  cmd_valid and frame_err are never high in the same cycle.
//  Width rules: idx is $clog2(TIME_BYTES+2) bits; timer is $clog2(TIMEOUT_CYC+1) bits, saturating.
// STRUCTURE
//  Package uart_cmd_pkg: FSM state encoding (IDLE,S_HDR1,S_ADDR,S_DATA,S_CHK,S_TAIL),
//   ERR_* codes, default header/tail constants.
//  Sub-module uart_cmd_timer: inter-byte timeout counter (inputs clear/enable, output expired).
//   Everything else is flat in uart_cmd_parser.
// TESTING  (NUM_CH=4, TIME_BYTES=4, CHK_EN=1, TIMEOUT_CYC=100)
//  1. 55 A5 02 00 00 C3 50 07 96 F0 -> ch2 time_set=32'h0000C350, ctrl_set=8'h07;
//     cmd_valid 1 cycle with cmd_ch=2; ch0/1/3 stay 0.
//  2. Same frame with CHK=97 -> frame_err, err_code=2; outputs unchanged.
//     Following valid frame for ch1 commits correctly.
//  3. ADDR=04 -> err 1. Tail byte 0F -> err 3. Neither modifies any channel.
//  4. 55 55 A5 01 ... valid -> header resync, ch1 commits. Noise 12 34 before 55 -> ignored, no error.
//  5. Stall 101 cycles after the 3rd payload byte -> err 4, FSM in IDLE.
//     A stall of 100 cycles with the next byte arriving on the expiry cycle -> no error.
//  6. Assert reset mid-payload -> all outputs 0. A full frame after release commits normally.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command parser: FSM state encoding,
// error codes, default framing bytes and the running checksum helper.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR1 = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_TAIL = 3'd5;

    // Error codes reported on err_code
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ADDR    = 3'd1;
    localparam logic [2:0] ERR_CHK     = 3'd2;
    localparam logic [2:0] ERR_TAIL    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Default framing bytes
    localparam logic [7:0] DEF_HDR0 = 8'h55;
    localparam logic [7:0] DEF_HDR1 = 8'hA5;
    localparam logic [7:0] DEF_TAIL = 8'hF0;

    // Running frame checksum: XOR of every byte from ADDR through CTRL
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser_if
// Bundles the byte stream from the UART receiver and the decoded register
// outputs of the command parser.
//   rx_done/rx_data      : byte strobe and data into the parser
//   time_set/ctrl_set    : per-channel register sets (channel k at slice k)
//   cmd_valid/cmd_ch     : commit pulse and the channel that was updated
//   frame_err/err_code   : abort pulse and the sticky reason code
// master modport = byte source / result consumer, slave modport = parser.
// -----------------------------------------------------------------------------
interface uart_cmd_parser_if #(
    parameter int NUM_CH     = 4,
    parameter int TIME_BYTES = 4
);
    logic                           rx_done;
    logic [7:0]                     rx_data;
    logic [NUM_CH*TIME_BYTES*8-1:0] time_set;
    logic [NUM_CH*8-1:0]            ctrl_set;
    logic                           cmd_valid;
    logic [7:0]                     cmd_ch;
    logic                           frame_err;
    logic [2:0]                     err_code;

    modport master (
        output rx_done, rx_data,
        input  time_set, ctrl_set, cmd_valid, cmd_ch, frame_err, err_code
    );

    modport slave (
        input  rx_done, rx_data,
        output time_set, ctrl_set, cmd_valid, cmd_ch, frame_err, err_code
    );
endinterface

// File: rtl/uart_cmd_parser_timer.sv
// -----------------------------------------------------------------------------
// uart_cmd_timer
// Inter-byte timeout counter. Counts cycles while enabled, restarts from zero
// on clear, saturates at its maximum. expired_o is high while enabled and the
// count equals TIMEOUT_CYC. TIMEOUT_CYC = 0 disables expiry entirely.
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : restart the count (byte received, or parser idle)
//   enable_i   : count this cycle (parser inside a frame)
//   expired_o  : timeout reached
// -----------------------------------------------------------------------------
module uart_cmd_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int           CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LIMIT  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam bit           TO_EN   = (TIMEOUT_CYC > 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise a saturating increment while enabled
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = TO_EN && enable_i && (count_q == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Frame-level command parser behind a UART receiver. Hunts for HDR0 HDR1,
// then decodes ADDR, TIME_BYTES big-endian time bytes, CTRL, an optional XOR
// checksum and TAIL. A good frame commits its shadow copy into the addressed
// channel's time_set/ctrl_set one cycle after TAIL; a bad or partial frame
// never touches those outputs.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : uart_cmd_parser_if slave (byte stream in, registers out)
// -----------------------------------------------------------------------------
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter int         TIME_BYTES  = 4,
    parameter logic [7:0] HDR0        = DEF_HDR0,
    parameter logic [7:0] HDR1        = DEF_HDR1,
    parameter logic [7:0] TAIL        = DEF_TAIL,
    parameter bit         CHK_EN      = 1'b1,
    parameter int         TIMEOUT_CYC = 50000
) (
    input logic              clk,
    input logic              reset,
    uart_cmd_parser_if.slave bus
);
    localparam int              TW       = TIME_BYTES * 8;
    localparam int              IDXW     = $clog2(TIME_BYTES + 2);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TIME_BYTES);

    logic [2:0]             state_q,     state_d;
    logic [7:0]             ch_q,        ch_d;
    logic [7:0]             chk_q,       chk_d;
    logic [IDXW-1:0]        idx_q,       idx_d;
    // shadow[0..TIME_BYTES-1] = time bytes MSB first, shadow[TIME_BYTES] = CTRL
    logic [7:0]             shadow_q [TIME_BYTES+1];
    logic [7:0]             shadow_d [TIME_BYTES+1];
    logic [NUM_CH*TW-1:0]   time_set_q,  time_set_d;
    logic [NUM_CH*8-1:0]    ctrl_set_q,  ctrl_set_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             cmd_ch_q,    cmd_ch_d;
    logic                   frame_err_q, frame_err_d;
    logic [2:0]             err_code_q,  err_code_d;

    logic [TW-1:0]          time_v_s;
    logic                   expired_s;
    logic                   in_frame_s;

    assign in_frame_s = (state_q != ST_IDLE);

    uart_cmd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (bus.rx_done || !in_frame_s),
        .enable_i  (in_frame_s),
        .expired_o (expired_s)
    );

    // Assemble the big-endian time value from the shadow bytes
    always_comb begin
        time_v_s = '0;
        for (int i = 0; i < TIME_BYTES; i++) begin
            time_v_s[(TIME_BYTES-1-i)*8 +: 8] = shadow_q[i];
        end
    end

    // Frame FSM, shadow capture, commit and error reporting
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        time_set_d  = time_set_q;
        ctrl_set_d  = ctrl_set_q;
        cmd_valid_d = 1'b0;
        cmd_ch_d    = cmd_ch_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        // A byte on the expiry cycle is processed normally, so rx_done has priority
        if (bus.rx_done) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = (bus.rx_data == HDR0) ? ST_HDR1 : ST_IDLE;
                end
                ST_HDR1: begin
                    if (bus.rx_data == HDR1) begin
                        state_d = ST_ADDR;
                    end else if (bus.rx_data == HDR0) begin
                        state_d = ST_HDR1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    // 9-bit compare so NUM_CH = 256 accepts every address
                    if ({1'b0, bus.rx_data} < 9'(NUM_CH)) begin
                        ch_d    = bus.rx_data;
                        chk_d   = bus.rx_data;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_ADDR;
                    end
                end
                ST_DATA: begin
                    for (int i = 0; i <= TIME_BYTES; i++) begin
                        shadow_d[i] = (idx_q == IDXW'(i)) ? bus.rx_data : shadow_q[i];
                    end
                    chk_d = chk_update(chk_q, bus.rx_data);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = CHK_EN ? ST_CHK : ST_TAIL;
                    end else begin
                        idx_d   = idx_q + IDXW'(1);
                        state_d = ST_DATA;
                    end
                end
                ST_CHK: begin
                    if (bus.rx_data == chk_q) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                end
                ST_TAIL: begin
                    // Either way the byte is consumed; a wrong tail is not re-hunted as HDR0
                    state_d = ST_IDLE;
                    if (bus.rx_data == TAIL) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            time_set_d[k*TW +: TW] = (ch_q == 8'(k)) ? time_v_s
                                                                    : time_set_q[k*TW +: TW];
                            ctrl_set_d[k*8 +: 8]   = (ch_q == 8'(k)) ? shadow_q[TIME_BYTES]
                                                                    : ctrl_set_q[k*8 +: 8];
                        end
                        cmd_valid_d = 1'b1;
                        cmd_ch_d    = ch_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_TAIL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (expired_s) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else begin
            state_d = state_q;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_q        <= 8'h00;
            chk_q       <= 8'h00;
            idx_q       <= '0;
            for (int i = 0; i <= TIME_BYTES; i++) begin
                shadow_q[i] <= 8'h00;
            end
            time_set_q  <= '0;
            ctrl_set_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_ch_q    <= 8'h00;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            time_set_q  <= time_set_d;
            ctrl_set_q  <= ctrl_set_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_ch_q    <= cmd_ch_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.time_set  = time_set_q;
    assign bus.ctrl_set  = ctrl_set_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_ch    = cmd_ch_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed bench for uart_cmd_parser (NUM_CH=4, TIME_BYTES=4, CHK_EN=1,
// TIMEOUT_CYC=100). Expected commits/errors are queued as frames are sent and
// matched against the DUT's cmd_valid/frame_err pulses by a monitor, which
// also maintains a model of every channel's registers.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int NC = 4;
    localparam int TB = 4;
    localparam int TO = 100;

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        logic [7:0] ch;
        logic [31:0] tv;
        logic [7:0] cv;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t        exp_q[$];
    logic [31:0] m_time [NC];
    logic [7:0]  m_ctrl [NC];
    logic [2:0]  m_code;

    always #5 clk = ~clk;

    uart_cmd_parser_if #(.NUM_CH(NC), .TIME_BYTES(TB)) bus ();

    uart_cmd_parser #(
        .NUM_CH      (NC),
        .TIME_BYTES  (TB),
        .HDR0        (8'h55),
        .HDR1        (8'hA5),
        .TAIL        (8'hF0),
        .CHK_EN      (1'b1),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_time();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[k*32 +: 32] = m_time[k];
        return v;
    endfunction

    function automatic logic [31:0] model_ctrl();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[k*8 +: 8] = m_ctrl[k];
        return v;
    endfunction

    // Monitor: every pulse must match the head of the expectation queue
    always @(posedge clk) begin
        #1;
        if (!reset && (bus.cmd_valid || bus.frame_err)) begin
            chk("pulse_exclusive", {127'd0, bus.cmd_valid & bus.frame_err}, 128'd0);
            chk("event_expected", {127'd0, exp_q.size() > 0}, 128'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    m_code = e.code;
                    chk("frame_err", {127'd0, bus.frame_err}, 128'd1);
                    chk("err_code", {125'd0, bus.err_code}, {125'd0, e.code});
                end else begin
                    m_time[e.ch] = e.tv;
                    m_ctrl[e.ch] = e.cv;
                    chk("cmd_valid", {127'd0, bus.cmd_valid}, 128'd1);
                    chk("cmd_ch", {120'd0, bus.cmd_ch}, {120'd0, e.ch});
                end
                chk("time_set", bus.time_set, model_time());
                chk("ctrl_set", {96'd0, bus.ctrl_set}, {96'd0, model_ctrl()});
            end
        end
    end

    task automatic push_cmd(input logic [7:0] ch, input logic [31:0] tv, input logic [7:0] cv);
        exp_t e;
        e.is_err = 1'b0; e.code = 3'd0; e.ch = ch; e.tv = tv; e.cv = cv;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.ch = 8'd0; e.tv = 32'd0; e.cv = 8'd0;
        exp_q.push_back(e);
    endtask

    // gap = number of idle clock edges before this byte's strobe
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap - 1) @(negedge clk);
        @(negedge clk);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] s[$]);
        for (int i = 0; i < s.size(); i++) send_byte(s[i], 1);
    endtask

    // Full frame; chk_flip corrupts the checksum, stall_len is the gap before payload byte stall_pos
    task automatic send_frame(input logic [7:0] ch, input logic [31:0] tv, input logic [7:0] cv,
                              input logic [7:0] chk_flip, input logic [7:0] tail,
                              input int stall_pos, input int stall_len);
        logic [7:0] p [5];
        logic [7:0] c;
        p[0] = tv[31:24]; p[1] = tv[23:16]; p[2] = tv[15:8]; p[3] = tv[7:0]; p[4] = cv;
        c = ch;
        for (int i = 0; i < 5; i++) c = c ^ p[i];
        send_byte(8'h55, 1);
        send_byte(8'hA5, 1);
        send_byte(ch, 1);
        for (int i = 0; i < 5; i++) send_byte(p[i], (i == stall_pos) ? stall_len : 1);
        send_byte(c ^ chk_flip, 1);
        send_byte(tail, 1);
    endtask

    // Wait (bounded) for all expected pulses, then check the quiet state
    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
        chk({tag, "_time"}, bus.time_set, model_time());
        chk({tag, "_ctrl"}, {96'd0, bus.ctrl_set}, {96'd0, model_ctrl()});
        chk({tag, "_code"}, {125'd0, bus.err_code}, {125'd0, m_code});
        chk({tag, "_quiet"}, {126'd0, bus.cmd_valid, bus.frame_err}, 128'd0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < NC; k++) begin
            m_time[k] = 32'd0;
            m_ctrl[k] = 8'd0;
        end
        m_code = 3'd0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset_time", bus.time_set, 128'd0);
        chk("reset_misc", {96'd0, bus.ctrl_set}, 128'd0);
        chk("reset_pulses", {115'd0, bus.cmd_valid, bus.cmd_ch, bus.frame_err, bus.err_code}, 128'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: literal frame for channel 2
        push_cmd(8'd2, 32'h0000C350, 8'h07);
        send_list('{8'h55, 8'hA5, 8'h02, 8'h00, 8'h00, 8'hC3, 8'h50, 8'h07, 8'h96, 8'hF0});
        drain_and_check("t1");

        // 2: bad checksum, then a good frame for channel 1
        push_err(ERR_CHK);
        send_list('{8'h55, 8'hA5, 8'h02, 8'h00, 8'h00, 8'hC3, 8'h50, 8'h07, 8'h97, 8'hF0});
        drain_and_check("t2_bad");
        push_cmd(8'd1, 32'h12345678, 8'h5A);
        send_frame(8'd1, 32'h12345678, 8'h5A, 8'h00, 8'hF0, -1, 1);
        drain_and_check("t2_good");

        // 3: address out of range, then a wrong tail
        push_err(ERR_ADDR);
        send_list('{8'h55, 8'hA5, 8'h04});
        drain_and_check("t3_addr");
        push_err(ERR_TAIL);
        send_frame(8'd3, 32'hDEADBEEF, 8'h11, 8'h00, 8'h0F, -1, 1);
        drain_and_check("t3_tail");

        // 4: noise, then a doubled HDR0 before a good frame for channel 1
        send_list('{8'h12, 8'h34, 8'h55});
        push_cmd(8'd1, 32'hAABBCCDD, 8'h3C);
        send_frame(8'd1, 32'hAABBCCDD, 8'h3C, 8'h00, 8'hF0, -1, 1);
        drain_and_check("t4");

        // 5: 101-cycle stall after the 3rd payload byte times out
        push_err(ERR_TIMEOUT);
        send_list('{8'h55, 8'hA5, 8'h00, 8'h11, 8'h22, 8'h33});
        repeat (120) @(negedge clk);
        drain_and_check("t5_timeout");
        push_cmd(8'd0, 32'h01020304, 8'h99);
        send_frame(8'd0, 32'h01020304, 8'h99, 8'h00, 8'hF0, -1, 1);
        drain_and_check("t5_idle");
        // 100-cycle stall: the next byte lands on the expiry cycle and is accepted
        push_cmd(8'd3, 32'hCAFEF00D, 8'h42);
        send_frame(8'd3, 32'hCAFEF00D, 8'h42, 8'h00, 8'hF0, 3, 100);
        drain_and_check("t5_edge");

        // 6: reset mid-payload clears everything; the next frame commits normally
        send_list('{8'h55, 8'hA5, 8'h02, 8'h11, 8'h22});
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        chk("t6_reset_time", bus.time_set, 128'd0);
        chk("t6_reset_misc", {96'd0, bus.ctrl_set}, 128'd0);
        chk("t6_reset_pulses", {115'd0, bus.cmd_valid, bus.cmd_ch, bus.frame_err, bus.err_code}, 128'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push_cmd(8'd2, 32'h0BADCAFE, 8'h81);
        send_frame(8'd2, 32'h0BADCAFE, 8'h81, 8'h00, 8'hF0, -1, 1);
        drain_and_check("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
